pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register. Next generation of the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic datapath bundle, a control bundle and a PC through one stage.
- Adds valid/ready flow control with a 1-entry skid buffer, plus flush with bubble insertion.
- Provides saturating stall/bubble/flush performance counters for the hazard unit and debug.

Parameters:
DATA_W, 128, width of datapath bundle (operands, imm, instr, register indices)
CTRL_W, 32, width of control bundle; all-zero encodes a NOP
PC_W, 32, PC width
RESET_PC, 32'h00003000, PC value loaded on reset/flush
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held and incoming content
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept (registered)
in_data  in  DATA_W  upstream datapath bundle
in_ctrl  in  CTRL_W  upstream control bundle
in_pc  in  PC_W  upstream PC
out_valid  out  1  output bundle valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  registered datapath bundle
out_ctrl  out  CTRL_W  registered control bundle (zero when out_valid=0)
out_pc  out  PC_W  registered PC
stall_cnt  out  CNT_W  cycles with out_valid&!out_ready
bubble_cnt  out  CNT_W  cycles with !out_valid&out_ready
flush_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=0, out_pc=RESET_PC.
  - Skid entry invalid, contents 0, skid pc=RESET_PC.
  - in_ready=1; all counters 0.
- Transfers: in-fire = in_valid&in_ready; out-fire = out_valid&out_ready.
- Latency: 1 cycle from in-fire to out_valid when the main register is empty or draining.
- Storage states (main valid M, skid valid S):
  - EMPTY (M=0,S=0).
  - ONE (M=1,S=0).
  - FULL (M=1,S=1).
  - S=1 with M=0 is illegal.
- Transitions, when flush=0:
  - EMPTY: in-fire -> ONE (main loads in_*).
  - ONE:
    - in-fire & out-fire -> ONE (main reloads).
    - in-fire & !out-fire -> FULL (skid captures in_*).
    - !in-fire & out-fire -> EMPTY.
    - Otherwise hold.
  - FULL:
    - out-fire -> ONE (main loads skid contents, skid invalidated).
    - Otherwise hold.
    - in_ready=0, so no in-fire can occur.
- in_ready is a register, equal to !S of next state. Combinational in->out ready paths are forbidden.
- Whenever main becomes empty, out_ctrl is cleared to 0. out_data and out_pc retain their last value.
- Flush (synchronous, highest priority below reset):
  - Next cycle: EMPTY, out_ctrl=0, out_data=0, out_pc=RESET_PC, in_ready=1.
  - A same-cycle in-fire is discarded.
  - A same-cycle out-fire is still consumed downstream, with no effect here.
- Bubble guarantee: out_valid=0 implies out_ctrl=0, so downstream may ignore out_valid and still see a NOP.
- Counters:
  - Evaluated on pre-edge state; +1 per qualifying cycle.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Not cleared by flush, only by reset.
- Reset asserted mid-transfer: all state is dropped immediately. Deassertion is synchronous to clk by system convention.
- Ordering: strict FIFO. No bundle is duplicated or lost except by flush.

Test Plan:
1. Reset then idle, out_ready=1 for 5 cycles -> out_valid=0, out_ctrl=0, out_pc=32'h00003000, in_ready=1, bubble_cnt=5.
2. Stream three bundles (pc 0x3000/0x3004/0x3008, ctrl 0x1/0x2/0x3), out_ready=1 -> each appears exactly 1 cycle after in-fire, in order; stall_cnt=0.
3. Backpressure:
   - Stimulus: send A (pc 0x3000), then B (0x3004) while out_ready=0; hold out_ready=0 for 3 cycles.
   - Required: in_ready falls to 0 one cycle after B fires; A held; stall_cnt=3.
   - Then out_ready=1: A out, then B next cycle, in_ready=1 again.
4. Flush in FULL state with in_valid=1 (pc 0x300C) -> next cycle out_valid=0, out_ctrl=0, out_pc=0x3000, in_ready=1; A, B and 0x300C never emerge; flush_cnt=1.
5. Reset pulse while FULL -> all outputs return to reset values asynchronously within the same cycle; counters 0.
6. CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline-stage register with skid buffer, flush and perf counters
//
// Purpose:
//   Carries a datapath bundle, a control bundle and a PC through one pipeline
//   stage with valid/ready flow control. A one-entry skid buffer lets in_ready
//   be a pure register, so no combinational path runs from out_ready to in_ready.
//   A flush empties the stage and inserts a bubble. Saturating counters
//   record stall, bubble and flush cycles.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   flush                     synchronous kill of held and incoming content
//   in_valid/in_ready         upstream handshake (in_ready registered)
//   in_data/in_ctrl/in_pc     upstream bundle
//   out_valid/out_ready       downstream handshake
//   out_data/out_ctrl/out_pc  registered bundle (out_ctrl is 0 whenever out_valid is 0)
//   stall_cnt                 cycles with out_valid & !out_ready
//   bubble_cnt                cycles with !out_valid & out_ready
//   flush_cnt                 cycles with flush high

module pipe_stage_reg #(
   parameter int              DATA_W   = 128,
   parameter int              CTRL_W   = 32,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h00003000,
   parameter int              CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [PC_W-1:0]   out_pc,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // main register (drives the outputs directly)
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CTRL_W-1:0] m_ctrl;
   logic [PC_W-1:0]   m_pc;

   // skid register
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic [CTRL_W-1:0] s_ctrl;
   logic [PC_W-1:0]   s_pc;

   logic              in_ready_q;

   // next-state values
   logic              m_valid_n;
   logic [DATA_W-1:0] m_data_n;
   logic [CTRL_W-1:0] m_ctrl_n;
   logic [PC_W-1:0]   m_pc_n;
   logic              s_valid_n;
   logic [DATA_W-1:0] s_data_n;
   logic [CTRL_W-1:0] s_ctrl_n;
   logic [PC_W-1:0]   s_pc_n;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = m_valid & out_ready;

   always_comb begin
      m_valid_n = m_valid;
      m_data_n  = m_data;
      m_ctrl_n  = m_ctrl;
      m_pc_n    = m_pc;
      s_valid_n = s_valid;
      s_data_n  = s_data;
      s_ctrl_n  = s_ctrl;
      s_pc_n    = s_pc;

      if (flush) begin
         // any same-cycle in-fire is dropped; an out-fire needs no action here
         m_valid_n = 1'b0;
         m_data_n  = '0;
         m_ctrl_n  = '0;
         m_pc_n    = RESET_PC;
         s_valid_n = 1'b0;
         s_data_n  = '0;
         s_ctrl_n  = '0;
         s_pc_n    = RESET_PC;
      end else begin
         case ({m_valid, s_valid})
            2'b00: begin
               if (in_fire) begin
                  m_valid_n = 1'b1;
                  m_data_n  = in_data;
                  m_ctrl_n  = in_ctrl;
                  m_pc_n    = in_pc;
               end
            end
            2'b10: begin
               if (in_fire && out_fire) begin
                  m_data_n  = in_data;
                  m_ctrl_n  = in_ctrl;
                  m_pc_n    = in_pc;
               end else if (in_fire) begin
                  s_valid_n = 1'b1;
                  s_data_n  = in_data;
                  s_ctrl_n  = in_ctrl;
                  s_pc_n    = in_pc;
               end else if (out_fire) begin
                  // emptying main turns the output into a NOP bubble
                  m_valid_n = 1'b0;
                  m_ctrl_n  = '0;
               end
            end
            2'b11: begin
               if (out_fire) begin
                  m_data_n  = s_data;
                  m_ctrl_n  = s_ctrl;
                  m_pc_n    = s_pc;
                  s_valid_n = 1'b0;
               end
            end
            default: begin
               // skid valid with main empty cannot be reached; recover to EMPTY
               s_valid_n = 1'b0;
               m_ctrl_n  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_ctrl     <= '0;
         m_pc       <= RESET_PC;
         s_valid    <= 1'b0;
         s_data     <= '0;
         s_ctrl     <= '0;
         s_pc       <= RESET_PC;
         in_ready_q <= 1'b1;
      end else begin
         m_valid    <= m_valid_n;
         m_data     <= m_data_n;
         m_ctrl     <= m_ctrl_n;
         m_pc       <= m_pc_n;
         s_valid    <= s_valid_n;
         s_data     <= s_data_n;
         s_ctrl     <= s_ctrl_n;
         s_pc       <= s_pc_n;
         in_ready_q <= ~s_valid_n;
      end
   end

   // counters look at pre-edge state and stick at their maximum
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (m_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (!m_valid && out_ready && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         if (flush && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_ctrl  = m_ctrl;
   assign out_pc    = m_pc;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [31:0]  in_ctrl;
   logic [31:0]  in_pc;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [31:0]  out_ctrl;
   logic [31:0]  out_pc;
   logic [15:0]  stall_cnt;
   logic [15:0]  bubble_cnt;
   logic [15:0]  flush_cnt;

   // narrow-counter copy sharing the same stimulus
   logic         n_in_ready;
   logic         n_out_valid;
   logic [127:0] n_out_data;
   logic [31:0]  n_out_ctrl;
   logic [31:0]  n_out_pc;
   logic [3:0]   n_stall_cnt;
   logic [3:0]   n_bubble_cnt;
   logic [3:0]   n_flush_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .out_pc(out_pc),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.CNT_W(4)) dut_n (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_pc(in_pc),
      .out_valid(n_out_valid), .out_ready(out_ready),
      .out_data(n_out_data), .out_ctrl(n_out_ctrl), .out_pc(n_out_pc),
      .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt), .flush_cnt(n_flush_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are examined 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] ctrl);
      in_valid = 1'b1;
      in_pc    = pc;
      in_ctrl  = ctrl;
      in_data  = {96'h0, pc ^ 32'hA5A5_0000};
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_pc    = '0;
      in_ctrl  = '0;
      in_data  = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #10;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      idle_in();

      // 1: reset, then idle with out_ready high
      do_reset();
      chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
      chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
      chk("rst_out_pc", {96'h0, out_pc}, 128'h3000);
      chk("rst_out_data", out_data, 128'h0);
      chk("rst_stall", {112'h0, stall_cnt}, 128'h0);
      for (int i = 0; i < 5; i++) tick();
      chk("idle_out_valid", {127'h0, out_valid}, 128'h0);
      chk("idle_out_ctrl", {96'h0, out_ctrl}, 128'h0);
      chk("idle_bubble", {112'h0, bubble_cnt}, 128'd5);

      // 2: three bundles streaming, one-cycle latency, in order
      for (int i = 0; i < 3; i++) begin
         send(32'h3000 + 32'(4 * i), 32'(i + 1));
         tick();
         chk("stream_valid", {127'h0, out_valid}, 128'h1);
         chk("stream_pc", {96'h0, out_pc}, {96'h0, 32'h3000 + 32'(4 * i)});
         chk("stream_ctrl", {96'h0, out_ctrl}, {96'h0, 32'(i + 1)});
         chk("stream_in_ready", {127'h0, in_ready}, 128'h1);
      end
      idle_in();
      tick();
      chk("drain_valid", {127'h0, out_valid}, 128'h0);
      chk("drain_ctrl_zero", {96'h0, out_ctrl}, 128'h0);
      chk("drain_pc_kept", {96'h0, out_pc}, 128'h3008);
      chk("stream_stall", {112'h0, stall_cnt}, 128'h0);

      // 3: backpressure into the skid buffer
      out_ready = 1'b0;
      send(32'h3000, 32'h11);
      tick();
      chk("bp_a_loaded", {96'h0, out_pc}, 128'h3000);
      chk("bp_ready_one", {127'h0, in_ready}, 128'h1);
      send(32'h3004, 32'h12);
      tick();
      chk("bp_ready_full", {127'h0, in_ready}, 128'h0);
      idle_in();
      tick();
      tick();
      chk("bp_a_held", {96'h0, out_pc}, 128'h3000);
      chk("bp_a_ctrl", {96'h0, out_ctrl}, 128'h11);
      chk("bp_stall", {112'h0, stall_cnt}, 128'd3);
      out_ready = 1'b1;
      tick();
      chk("bp_b_pc", {96'h0, out_pc}, 128'h3004);
      chk("bp_b_ctrl", {96'h0, out_ctrl}, 128'h12);
      chk("bp_b_data", out_data, {96'h0, 32'h3004 ^ 32'hA5A5_0000});
      chk("bp_ready_back", {127'h0, in_ready}, 128'h1);
      tick();
      chk("bp_empty", {127'h0, out_valid}, 128'h0);

      // 4: flush while FULL with an incoming bundle
      out_ready = 1'b0;
      send(32'h3000, 32'h21);
      tick();
      send(32'h3004, 32'h22);
      tick();
      send(32'h300C, 32'h23);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle_in();
      chk("fl_valid", {127'h0, out_valid}, 128'h0);
      chk("fl_ctrl", {96'h0, out_ctrl}, 128'h0);
      chk("fl_pc", {96'h0, out_pc}, 128'h3000);
      chk("fl_data", out_data, 128'h0);
      chk("fl_in_ready", {127'h0, in_ready}, 128'h1);
      chk("fl_cnt", {112'h0, flush_cnt}, 128'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_nothing_out", {127'h0, out_valid}, 128'h0);
      end

      // 5: asynchronous reset while FULL
      out_ready = 1'b0;
      send(32'h3010, 32'h31);
      tick();
      send(32'h3014, 32'h32);
      tick();
      idle_in();
      chk("pre_rst_full", {127'h0, in_ready}, 128'h0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", {127'h0, out_valid}, 128'h0);
      chk("arst_ctrl", {96'h0, out_ctrl}, 128'h0);
      chk("arst_pc", {96'h0, out_pc}, 128'h3000);
      chk("arst_in_ready", {127'h0, in_ready}, 128'h1);
      chk("arst_stall", {112'h0, stall_cnt}, 128'h0);
      chk("arst_flush", {112'h0, flush_cnt}, 128'h0);
      chk("arst_bubble", {112'h0, bubble_cnt}, 128'h0);
      do_reset();

      // 6: long stall; 16-bit counter counts, 4-bit counter saturates
      out_ready = 1'b0;
      send(32'h3020, 32'h41);
      tick();
      idle_in();
      for (int i = 0; i < 16; i++) tick();
      chk("sat_n_reach", {124'h0, n_stall_cnt}, 128'd15);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_n_hold", {124'h0, n_stall_cnt}, 128'd15);
      chk("sat_wide", {112'h0, stall_cnt}, 128'd20);
      chk("sat_held_pc", {96'h0, out_pc}, 128'h3020);
      out_ready = 1'b1;
      tick();
      chk("sat_release", {127'h0, out_valid}, 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
